// File: rtl/multi_lane_solver.sv
// Nonce-search scheduler for one block-header job spread over LANES hash lanes with interleaved nonce slices.
// Optional result counter on hashes_done is enabled by defining MULTI_LANE_SOLVER_STATS_EN.
module multi_lane_solver #(
  parameter int LANES           = 4,
  parameter int NONCE_W         = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [255:0]               midstate,
  input  logic [95:0]                header_leftovers,
  input  logic [255:0]               target,
  output logic [255:0]               job_midstate,
  output logic [95:0]                job_leftovers,
  output logic [LANES-1:0]           lane_issue_valid,
  input  logic [LANES-1:0]           lane_issue_ready,
  output logic [LANES*NONCE_W-1:0]   lane_nonce,
  input  logic [LANES-1:0]           lane_result_valid,
  input  logic [LANES*NONCE_W-1:0]   lane_result_nonce,
  input  logic [LANES*256-1:0]       lane_hash,
  output logic [2:0]                 state_out,
  output logic                       found,
  output logic [NONCE_W-1:0]         nonce,
  output logic [47:0]                hashes_done
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_RUN       = 3'd2,
    S_DRAIN     = 3'd3,
    S_FOUND     = 3'd4,
    S_EXHAUSTED = 3'd5
  } state_t;

  localparam int                OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0]  MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [NONCE_W:0]  STRIDE  = (NONCE_W + 1)'(LANES);

  state_t             state;
  logic [255:0]       job_target;
  logic [NONCE_W-1:0] lane_cnt [LANES];
  logic [NONCE_W:0]   lane_sum [LANES];
  logic [OUT_W-1:0]   lane_out [LANES];
  logic [LANES-1:0]   lane_exh;
  logic [LANES-1:0]   issue_fire;
  logic [LANES-1:0]   hit;
  logic               all_idle;
  logic [NONCE_W-1:0] win_nonce;

  assign state_out = state;

  always_comb begin
    lane_issue_valid = '0;
    lane_nonce       = '0;
    hit              = '0;
    all_idle         = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      lane_issue_valid[i] = (state == S_RUN) && !lane_exh[i] && (lane_out[i] < MAX_OUT);
      lane_nonce[i*NONCE_W +: NONCE_W] = lane_cnt[i];
      lane_sum[i] = {1'b0, lane_cnt[i]} + STRIDE;
      hit[i] = lane_result_valid[i] && (lane_hash[i*256 +: 256] <= job_target);
      if (lane_out[i] != '0) all_idle = 1'b0;
    end
    issue_fire = lane_issue_valid & lane_issue_ready;
  end

  // Scan from the top so the lowest-indexed hitting lane is the one that sticks.
  always_comb begin
    win_nonce = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit[i]) win_nonce = lane_result_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      found         <= 1'b0;
      nonce         <= '0;
      job_midstate  <= '0;
      job_leftovers <= '0;
      job_target    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            job_midstate  <= midstate;
            job_leftovers <= header_leftovers;
            job_target    <= target;
            state         <= S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (|hit) begin
            state <= S_FOUND;
            found <= 1'b1;
            nonce <= win_nonce;
          end else if (state == S_RUN && (&lane_exh)) begin
            state <= S_DRAIN;
          end else if (state == S_DRAIN && all_idle) begin
            state <= S_EXHAUSTED;
          end
        end
        S_FOUND, S_EXHAUSTED: begin
          if (abort) begin
            state <= S_IDLE;
            found <= 1'b0;
          end else if (start) begin
            state <= S_LOAD;
            found <= 1'b0;
            nonce <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issue and result on one lane in one cycle cancel; results never drive the count below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin
        lane_cnt[i] <= '0;
        lane_out[i] <= '0;
      end
      lane_exh <= '0;
    end else if (state == S_LOAD) begin
      for (int i = 0; i < LANES; i++) begin
        lane_cnt[i] <= NONCE_W'(i);
        lane_out[i] <= '0;
      end
      lane_exh <= '0;
    end else if (state == S_RUN || state == S_DRAIN) begin
      for (int i = 0; i < LANES; i++) begin
        if (issue_fire[i]) begin
          lane_cnt[i] <= lane_sum[i][NONCE_W-1:0];
          if (lane_sum[i][NONCE_W]) lane_exh[i] <= 1'b1;
        end
        if (issue_fire[i] && !lane_result_valid[i]) begin
          lane_out[i] <= lane_out[i] + OUT_W'(1);
        end else if (!issue_fire[i] && lane_result_valid[i] && lane_out[i] != '0) begin
          lane_out[i] <= lane_out[i] - OUT_W'(1);
        end
      end
    end
  end

`ifdef MULTI_LANE_SOLVER_STATS_EN
  localparam int CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] result_cnt;
  logic [48:0]      hashes_sum;

  always_comb begin
    result_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      result_cnt = result_cnt + CNT_W'(lane_result_valid[i]);
    end
    hashes_sum = {1'b0, hashes_done} + 49'(result_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst || state == S_LOAD) begin
      hashes_done <= '0;
    end else if (state == S_RUN || state == S_DRAIN) begin
      hashes_done <= hashes_sum[48] ? '1 : hashes_sum[47:0];
    end
  end
`else
  assign hashes_done = '0;
`endif

endmodule

// File: tb/tb_multi_lane_solver.sv
// Directed bench for multi_lane_solver with LANES=4, NONCE_W=8, MAX_OUTSTANDING=2 and
// fixed-latency lane models driven from the stimulus task.
module tb_multi_lane_solver;

  localparam int LANES   = 4;
  localparam int NONCE_W = 8;
  localparam int MAX_OUT = 2;
  localparam int LAT     = 3;

  localparam logic [255:0] MID1 = 256'h4a03aeb2bcf3ad77d705828c4ec62fa2282784a285936a72c71636a4ddef7254;
  localparam logic [255:0] MID2 = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
  localparam logic [95:0]  LEFT1 = 96'h1d00ffff_4dd7f5c7_00000000;
  localparam logic [255:0] T_HIT = {88'h00000000000000000440C4, 168'h0};
`ifdef MULTI_LANE_SOLVER_STATS_EN
  localparam logic [47:0]  EXP_HASHES = 48'd40;
`else
  localparam logic [47:0]  EXP_HASHES = 48'd0;
`endif

  logic                     clk = 1'b0;
  logic                     rst, start, abort;
  logic [255:0]             midstate, target;
  logic [95:0]              header_leftovers;
  logic [255:0]             job_midstate;
  logic [95:0]              job_leftovers;
  logic [LANES-1:0]         lane_issue_valid, lane_issue_ready, lane_result_valid;
  logic [LANES*NONCE_W-1:0] lane_nonce, lane_result_nonce;
  logic [LANES*256-1:0]     lane_hash;
  logic [2:0]               state_out;
  logic                     found;
  logic [NONCE_W-1:0]       nonce;
  logic [47:0]              hashes_done;

  always #5 clk = ~clk;

  multi_lane_solver #(
    .LANES(LANES), .NONCE_W(NONCE_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .midstate(midstate), .header_leftovers(header_leftovers), .target(target),
    .job_midstate(job_midstate), .job_leftovers(job_leftovers),
    .lane_issue_valid(lane_issue_valid), .lane_issue_ready(lane_issue_ready),
    .lane_nonce(lane_nonce), .lane_result_valid(lane_result_valid),
    .lane_result_nonce(lane_result_nonce), .lane_hash(lane_hash),
    .state_out(state_out), .found(found), .nonce(nonce), .hashes_done(hashes_done)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  bit                 model_en;
  logic [LANES-1:0]   ready_mask, withhold;
  bit                 hit_en, hit_sent;
  logic [NONCE_W-1:0] hit_nonce;
  bit                 pv [LANES][LAT];
  logic [NONCE_W-1:0] pn [LANES][LAT];
  int                 fire_cnt [LANES];
  int                 lane2_next, lane2_err;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < LANES; i++) begin
      for (int s = 0; s < LAT; s++) begin
        pv[i][s] = 1'b0;
        pn[i][s] = '0;
      end
      fire_cnt[i] = 0;
    end
    lane2_next = 2;
    lane2_err  = 0;
    hit_sent   = 1'b0;
  endtask

  function automatic bit pipesEmpty();
    for (int i = 0; i < LANES; i++)
      for (int s = 0; s < LAT; s++)
        if (pv[i][s]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: lane models present due results and capture this cycle's accepts, then the edge passes.
  task automatic applyStimulus();
    lane_issue_ready = ready_mask;
    if (model_en) begin
      for (int i = 0; i < LANES; i++) begin
        lane_result_valid[i] = pv[i][LAT-1] && !withhold[i];
        lane_result_nonce[i*NONCE_W +: NONCE_W] = pn[i][LAT-1];
        if (hit_en && pn[i][LAT-1] == hit_nonce) begin
          lane_hash[i*256 +: 256] = {256{1'b0}};
          if (lane_result_valid[i]) hit_sent = 1'b1;
        end else begin
          lane_hash[i*256 +: 256] = {256{1'b1}};
        end
        for (int s = LAT - 1; s > 0; s--) begin
          pv[i][s] = pv[i][s-1];
          pn[i][s] = pn[i][s-1];
        end
        pv[i][0] = lane_issue_valid[i] && ready_mask[i];
        pn[i][0] = lane_nonce[i*NONCE_W +: NONCE_W];
        if (pv[i][0]) begin
          fire_cnt[i]++;
          if (i == 2) begin
            if (pn[2][0] != NONCE_W'(lane2_next)) lane2_err++;
            lane2_next += 4;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit saw_drain;
    int lane0_err;

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    midstate = '0; header_leftovers = '0; target = '0;
    lane_issue_ready = '0; lane_result_valid = '0; lane_result_nonce = '0; lane_hash = '0;
    model_en = 1'b0; ready_mask = '0; withhold = '0; hit_en = 1'b0; hit_nonce = '0;
    clearModel();

    // Reset state, with start asserted to show reset wins
    @(negedge clk);
    start = 1'b1;
    applyStimulus();
    applyStimulus();
    start = 1'b0;
    checkOutput("rst_state", 256'(state_out), 256'd0);
    checkOutput("rst_found", 256'(found), 256'd0);
    checkOutput("rst_nonce", 256'(nonce), 256'd0);
    checkOutput("rst_valid", 256'(lane_issue_valid), 256'd0);
    checkOutput("rst_lane_nonce", 256'(lane_nonce), 256'd0);
    checkOutput("rst_job_mid", job_midstate, 256'd0);
    checkOutput("rst_job_left", 256'(job_leftovers), 256'd0);
    checkOutput("rst_hashes", 256'(hashes_done), 256'd0);
    rst = 1'b0;

    // Search hits on lane 0 nonce C0
    midstate = MID1; header_leftovers = LEFT1; target = T_HIT;
    model_en = 1'b1; ready_mask = 4'hf; hit_en = 1'b1; hit_nonce = 8'hC0;
    clearModel();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("load_state", 256'(state_out), 256'd1);
    applyStimulus();
    checkOutput("run_state", 256'(state_out), 256'd2);
    checkOutput("job_midstate", job_midstate, MID1);
    checkOutput("job_leftovers", 256'(job_leftovers), 256'(LEFT1));
    checkOutput("run_first_nonces", 256'(lane_nonce), 256'h03020100);
    checkOutput("run_valids", 256'(lane_issue_valid), 256'hf);
    for (int c = 0; c < 1000 && !hit_sent; c++) applyStimulus();
    checkOutput("hit_returned", 256'(hit_sent), 256'd1);
    checkOutput("hit_state", 256'(state_out), 256'd4);
    checkOutput("hit_found", 256'(found), 256'd1);
    checkOutput("hit_nonce", 256'(nonce), 256'hC0);
    checkOutput("hit_valids", 256'(lane_issue_valid), 256'd0);
    applyStimulus();
    applyStimulus();
    applyStimulus();
    checkOutput("found_hold_state", 256'(state_out), 256'd4);
    checkOutput("found_hold_nonce", 256'(nonce), 256'hC0);

    // Full exhaustion of the 8-bit nonce space
    target = '0; hit_en = 1'b0;
    clearModel();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("restart_found_clr", 256'(found), 256'd0);
    checkOutput("restart_nonce_clr", 256'(nonce), 256'd0);
    applyStimulus();
    saw_drain = 1'b0;
    for (int c = 0; c < 3000 && state_out != 3'd5; c++) begin
      applyStimulus();
      if (state_out == 3'd3) saw_drain = 1'b1;
    end
    checkOutput("exh_state", 256'(state_out), 256'd5);
    checkOutput("exh_saw_drain", 256'(saw_drain), 256'd1);
    for (int i = 0; i < LANES; i++)
      checkOutput($sformatf("exh_issued_lane%0d", i), 256'(fire_cnt[i]), 256'd64);
    checkOutput("exh_lane2_sequence_errors", 256'(lane2_err), 256'd0);
    checkOutput("exh_all_results_back", 256'(pipesEmpty()), 256'd1);
    checkOutput("exh_valids", 256'(lane_issue_valid), 256'd0);
    checkOutput("exh_found", 256'(found), 256'd0);

    // Same-cycle hits on lanes 1 and 3
    target = T_HIT; model_en = 1'b0; ready_mask = '0;
    clearModel();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    checkOutput("dual_run_state", 256'(state_out), 256'd2);
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("start_ignored_in_run", 256'(state_out), 256'd2);
    lane_result_valid = 4'b1010;
    lane_result_nonce = {8'd7, 8'd0, 8'd5, 8'd0};
    lane_hash = {{256{1'b0}}, {256{1'b1}}, {256{1'b0}}, {256{1'b1}}};
    applyStimulus();
    lane_result_valid = '0;
    checkOutput("dual_state", 256'(state_out), 256'd4);
    checkOutput("dual_found", 256'(found), 256'd1);
    checkOutput("dual_nonce", 256'(nonce), 256'd5);
    lane_result_valid = 4'b0001;
    lane_result_nonce = '0;
    lane_hash = '0;
    applyStimulus();
    lane_result_valid = '0;
    checkOutput("late_hit_ignored_nonce", 256'(nonce), 256'd5);
    checkOutput("late_hit_ignored_state", 256'(state_out), 256'd4);

    // Backpressure on lane 0, withheld results on lane 1
    target = '0; model_en = 1'b1; ready_mask = 4'b1110; withhold = 4'b0010;
    clearModel();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("bp_found_cleared", 256'(found), 256'd0);
    applyStimulus();
    lane0_err = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus();
      if (!(lane_issue_valid[0] && lane_nonce[NONCE_W-1:0] == 8'd0)) lane0_err++;
    end
    checkOutput("bp_lane0_held_offer", 256'(lane0_err), 256'd0);
    checkOutput("bp_lane1_accepts", 256'(fire_cnt[1]), 256'd2);
    checkOutput("bp_lane1_valid", 256'(lane_issue_valid[1]), 256'd0);
    checkOutput("bp_lane1_nonce", 256'(lane_nonce[2*NONCE_W-1:NONCE_W]), 256'd9);
    ready_mask = 4'b1111;
    applyStimulus();
    checkOutput("bp_lane0_accepted", 256'(fire_cnt[0]), 256'd1);
    checkOutput("bp_lane0_next_nonce", 256'(lane_nonce[NONCE_W-1:0]), 256'd4);

    // Abort with work in flight, then a late hitting result
    model_en = 1'b0; ready_mask = '0; withhold = '0;
    lane_result_valid = '0;
    abort = 1'b1;
    applyStimulus();
    abort = 1'b0;
    checkOutput("abort_state", 256'(state_out), 256'd0);
    checkOutput("abort_valids", 256'(lane_issue_valid), 256'd0);
    applyStimulus();
    lane_result_valid = 4'b0100;
    lane_result_nonce = {8'd0, 8'd6, 8'd0, 8'd0};
    lane_hash = '0;
    applyStimulus();
    lane_result_valid = '0;
    checkOutput("abort_late_state", 256'(state_out), 256'd0);
    checkOutput("abort_late_found", 256'(found), 256'd0);

    // Restart re-latches a new job and reseeds lane counters
    midstate = MID2;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    checkOutput("relatch_state", 256'(state_out), 256'd2);
    checkOutput("relatch_midstate", job_midstate, MID2);
    checkOutput("relatch_nonces", 256'(lane_nonce), 256'h03020100);

    // Abort beats a hit in the same cycle
    abort = 1'b1;
    lane_result_valid = 4'b0001;
    lane_result_nonce = '0;
    lane_hash = '0;
    applyStimulus();
    abort = 1'b0;
    lane_result_valid = '0;
    checkOutput("abort_vs_hit_state", 256'(state_out), 256'd0);
    checkOutput("abort_vs_hit_found", 256'(found), 256'd0);

    // Result counter: 4 results per cycle for 10 cycles
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    applyStimulus();
    lane_result_valid = 4'hf;
    lane_result_nonce = {8'd3, 8'd2, 8'd1, 8'd0};
    lane_hash = {LANES*256{1'b1}};
    for (int c = 0; c < 10; c++) applyStimulus();
    lane_result_valid = '0;
    checkOutput("stats_count", 256'(hashes_done), 256'(EXP_HASHES));
    applyStimulus();
    checkOutput("stats_hold", 256'(hashes_done), 256'(EXP_HASHES));
    checkOutput("stats_state", 256'(state_out), 256'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/multi_lane_solver.md
Name: multi_lane_solver

Overview:
- Parametrised successor to the single-engine block solver.
- Schedules a nonce search across LANES external double-SHA256 hash lanes for one block header job.
- Each lane owns an interleaved nonce slice; the block compares each returned hash against the target, tracks in-flight work and reports FOUND or EXHAUSTED through the same state_out encoding as the single-engine solver.
- Sits between the job/host interface and the hash-lane array.

Parameters:
- LANES, 4, number of hash lanes; must be a power of 2, range 1..16.
- NONCE_W, 32, nonce width.
- MAX_OUTSTANDING, 8, maximum in-flight nonces per lane; range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  latch job and begin search.
- abort  in  1  drop job and return to IDLE.
- midstate  in  256  job midstate.
- header_leftovers  in  96  job header tail.
- target  in  256  job target; a hash is valid when hash <= target (unsigned).
- job_midstate  out  256  latched midstate, broadcast to all lanes.
- job_leftovers  out  96  latched header tail, broadcast to all lanes.
- lane_issue_valid  out  LANES  per-lane nonce offer.
- lane_issue_ready  in  LANES  per-lane accept.
- lane_nonce  out  LANES*NONCE_W  per-lane offered nonce; lane i occupies bits [i*NONCE_W +: NONCE_W].
- lane_result_valid  in  LANES  per-lane result strobe.
- lane_result_nonce  in  LANES*NONCE_W  nonce the result belongs to.
- lane_hash  in  LANES*256  result hash.
- state_out  out  3  FSM state.
- found  out  1  high in FOUND.
- nonce  out  NONCE_W  winning nonce.
- hashes_done  out  48  result counter (optional feature).

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE (0), found=0, nonce=0, lane_issue_valid=0, lane_nonce=0, job_* outputs=0, hashes_done=0, all counters cleared. Reset overrides every other input, including mid-search.
- State encoding: IDLE=0, LOAD=1, RUN=2, DRAIN=3, FOUND=4, EXHAUSTED=5.
- IDLE/FOUND/EXHAUSTED: start=1 goes to LOAD. In FOUND/EXHAUSTED, start also clears found and nonce.
- LOAD (1 cycle):
  - Latch midstate, header_leftovers and target into the job registers.
  - Set lane i counter to i and its outstanding count to 0; clear hashes_done.
  - Go to RUN.
- RUN:
  - Lane i offers valid=1 while it is not exhausted and outstanding < MAX_OUTSTANDING, with lane_nonce = its counter.
  - On valid&ready: counter += LANES and outstanding++.
  - If the addition carries out of NONCE_W bits, the lane is marked exhausted and its valid drops the next cycle.
  - When all lanes are exhausted, go to DRAIN.
- Results (RUN and DRAIN):
  - On lane_result_valid[i]: outstanding[i]-- (saturates at 0); the hash is compared combinationally and registered.
  - Issue and result on the same lane in the same cycle leave outstanding unchanged.
  - Any hit: state goes to FOUND and found=1 on the cycle after the strobe (1-cycle latency); nonce takes the hit's lane_result_nonce.
  - Multiple hits in one cycle: the lowest lane index wins.
- DRAIN: when all outstanding counts are 0 and there is no hit, go to EXHAUSTED.
- FOUND/EXHAUSTED:
  - All lane_issue_valid=0.
  - Further results are ignored; found, nonce and state are held.
- abort=1 in any state other than IDLE: go to IDLE the next cycle and drop valids. Late lane results are ignored. abort takes priority over start and over a same-cycle hit.
- start is ignored in LOAD, RUN and DRAIN.

Optional Feature:
- Macro: MULTI_LANE_SOLVER_STATS_EN.
- Defined: hashes_done increments by popcount(lane_result_valid) per cycle in RUN and DRAIN. It saturates at all-ones, clears in LOAD, and holds in FOUND/EXHAUSTED.
- Undefined: hashes_done is tied to 0 and no counter logic is synthesised.

Test Plan:
1. LANES=4, midstate=256'h4a03aeb2bcf3ad77d705828c4ec62fa2282784a285936a72c71636a4ddef7254, target=256'h00000000000000000440C4 followed by zeros, lane models always ready with 3-cycle latency. Models return a hash below target only for nonce 32'h9c9a4fc0 (lane 0). -> state_out=4 one cycle after that result, nonce=32'h9c9a4fc0, all valids low.
2. NONCE_W=8, LANES=4, target=0, hashes never hit -> each lane issues exactly 64 nonces. Lane 2 issues 2, 6, ..., 254. Result: DRAIN, then state_out=5 after the last result returns.
3. Same-cycle hits on lanes 1 and 3 with nonces 5 and 7 -> nonce=5, found=1.
4. Lane 0 ready held low for 20 cycles, MAX_OUTSTANDING=2, lane 1 results withheld -> lane 1 valid drops after 2 accepts. Lane 0 offers nonce 0 until accepted.
5. abort asserted in RUN with 3 results in flight; a hitting result arrives 2 cycles later -> state IDLE, found stays 0. A subsequent start re-latches the job and lane i restarts at nonce i.
6. With MULTI_LANE_SOLVER_STATS_EN: 4 lanes returning results every cycle for 10 cycles -> hashes_done=40. Without the macro -> hashes_done=0.
